// File: rtl/soc_pkg.sv
// soc_pkg: constants and types shared by the interrupt controller slice.
//   VEC_W               - width of a handler vector address (14)
//   HCU_STATE_INTERRUPT - hazard control unit state meaning "interrupt accepted"
//   irq_state_e         - controller FSM encoding (IDLE/REQUEST/SERVICE)
//   vec_addr()          - base + id * stride, truncated to VEC_W bits
package soc_pkg;

    localparam int unsigned VEC_W = 14;
    localparam logic [2:0] HCU_STATE_INTERRUPT = 3'h2;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StRequest = 2'b01,
        StService = 2'b10
    } irq_state_e;

    // Wrap-around past 14 bits is intentional; the upper bits are dropped.
    function automatic logic [VEC_W-1:0] vec_addr(input logic [VEC_W-1:0] base,
                                                   input logic [3:0] id,
                                                   input int unsigned stride);
        logic [31:0] full;
        full = 32'(base) + 32'(id) * stride;
        return full[VEC_W-1:0];
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: handshake between the interrupt controller and the
// hazard control unit.
//   interrupt                - request to the hazard unit
//   interrupt_vector_address - handler address, valid while interrupt = 1
//   control_state            - hazard unit state (3'h2 = interrupt accepted)
//   reti                     - one-cycle pulse when the handler return completes
// master = interrupt controller side, slave = hazard control unit side.
interface interrupt_controller_if;
    import soc_pkg::*;

    logic             interrupt;
    logic [VEC_W-1:0] interrupt_vector_address;
    logic [2:0]       control_state;
    logic             reti;

    modport master (
        output interrupt,
        output interrupt_vector_address,
        input  control_state,
        input  reti
    );

    modport slave (
        input  interrupt,
        input  interrupt_vector_address,
        output control_state,
        output reti
    );

endinterface

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder: combinational lowest-index-first priority encoder.
//   req   - request bits, NUM_IRQ wide
//   id    - index of the lowest set bit (0 when none set)
//   valid - at least one bit of req is set
module irq_priority_encoder #(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [3:0]         id,
    output logic               valid
);

    // Scan from the top down so the lowest set index is the last to write.
    always_comb begin
        id    = 4'd0;
        valid = 1'b0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                id    = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller: latches rising edges on external interrupt lines, masks
// and prioritises them, and presents one request at a time to the hazard
// control unit. Further requests are held until the handler returns (reti).
//   clock, nreset    - clock; synchronous active-low reset
//   irq_lines        - external requests, rising-edge sensitive
//   global_ie        - global interrupt enable (level)
//   mask_we/wdata    - mask write; 1 = source masked (reset: all masked)
//   hcu              - handshake with the hazard control unit (master side)
//   pending          - latched, not-yet-acknowledged edges
//   mask             - current mask register
//   in_service       - handler active
//   active_id        - source being requested or serviced
// Optional build macro IRQ_SYNC_EN: adds a two-flop synchronizer per line
// ahead of edge detection (request latency 4 cycles instead of 2).
module interrupt_controller
    import soc_pkg::*;
#(
    parameter int unsigned      NUM_IRQ    = 8,
    parameter logic [VEC_W-1:0] VEC_BASE   = 14'h0040,
    parameter int unsigned      VEC_STRIDE = 4
) (
    input  logic                   clock,
    input  logic                   nreset,
    input  logic [NUM_IRQ-1:0]     irq_lines,
    input  logic                   global_ie,
    input  logic                   mask_we,
    input  logic [NUM_IRQ-1:0]     mask_wdata,
    interrupt_controller_if.master hcu,
    output logic [NUM_IRQ-1:0]     pending,
    output logic [NUM_IRQ-1:0]     mask,
    output logic                   in_service,
    output logic [3:0]             active_id
);

    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] rise, clr;
    logic [3:0]         active_id_q, active_id_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [3:0]         win_id;
    logic               win_valid;
    logic               ack;
    irq_state_e         state_q, state_d;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync2_q;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_lines;
            sync2_q <= sync1_q;
        end
    end

    assign irq_in = sync2_q;
`else
    assign irq_in = irq_lines;
`endif

    assign rise = irq_in & ~irq_prev_q;
    assign ack  = (state_q == StRequest) && (hcu.control_state == HCU_STATE_INTERRUPT);

    always_comb begin
        clr = '0;
        if (ack) begin
            for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                if (active_id_q == 4'(i)) clr[i] = 1'b1;
            end
        end
    end

    // A new edge in the acknowledge cycle survives the clear.
    assign pending_d = (pending_q & ~clr) | rise;

    irq_priority_encoder #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .req   (pending_q & ~mask_q),
        .id    (win_id),
        .valid (win_valid)
    );

    always_comb begin
        state_d     = state_q;
        active_id_d = active_id_q;
        vec_d       = vec_q;
        case (state_q)
            StIdle: begin
                if (global_ie && win_valid) begin
                    state_d     = StRequest;
                    active_id_d = win_id;
                    vec_d       = vec_addr(VEC_BASE, win_id, VEC_STRIDE);
                end
            end
            // Committed: mask writes and global_ie drops do not withdraw it.
            StRequest: if (ack) state_d = StService;
            StService: if (hcu.reti) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q     <= StIdle;
            irq_prev_q  <= '0;
            pending_q   <= '0;
            mask_q      <= '1;
            active_id_q <= 4'd0;
            vec_q       <= '0;
        end else begin
            state_q     <= state_d;
            irq_prev_q  <= irq_in;
            pending_q   <= pending_d;
            active_id_q <= active_id_d;
            vec_q       <= vec_d;
            if (mask_we) mask_q <= mask_wdata;
        end
    end

    assign hcu.interrupt                = (state_q == StRequest);
    assign hcu.interrupt_vector_address = vec_q;
    assign pending                      = pending_q;
    assign mask                         = mask_q;
    assign in_service                   = (state_q == StService);
    assign active_id                    = active_id_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed stimulus pushes the expected
// (id, vector) of every request into a queue; a monitor pops and compares
// each time interrupt rises.
module tb_interrupt_controller;

`ifdef IRQ_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic       clock = 1'b0;
    logic       nreset;
    logic [7:0] irq_lines;
    logic       global_ie;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [7:0] pending;
    logic [7:0] mask;
    logic       in_service;
    logic [3:0] active_id;

    interrupt_controller_if hcu ();

    interrupt_controller #(
        .NUM_IRQ    (8),
        .VEC_BASE   (14'h0040),
        .VEC_STRIDE (4)
    ) dut (
        .clock      (clock),
        .nreset     (nreset),
        .irq_lines  (irq_lines),
        .global_ie  (global_ie),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .hcu        (hcu),
        .pending    (pending),
        .mask       (mask),
        .in_service (in_service),
        .active_id  (active_id)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  id;
        logic [13:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [3:0] id, input logic [13:0] vec);
        exp_t e;
        e.id  = id;
        e.vec = vec;
        exp_q.push_back(e);
    endtask

    // Acknowledge the current request, then check SERVICE entry.
    task automatic ack_req(input logic [7:0] exp_pend);
        hcu.control_state = 3'h2;
        tick(1);
        hcu.control_state = 3'h0;
        chk("ack_drops_interrupt", 32'(hcu.interrupt), 32'd0);
        chk("ack_in_service", 32'(in_service), 32'd1);
        chk("ack_pending", 32'(pending), 32'(exp_pend));
    endtask

    task automatic do_reti();
        hcu.reti = 1'b1;
        tick(1);
        hcu.reti = 1'b0;
        chk("reti_idle", 32'(in_service), 32'd0);
    endtask

    // Monitor: compare every new request against the scoreboard.
    initial begin
        logic int_prev;
        exp_t e;
        int_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (hcu.interrupt && !int_prev) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_request: id %0d vec %0h, expected none",
                             active_id, hcu.interrupt_vector_address);
                end else begin
                    e = exp_q.pop_front();
                    chk("req_vector", 32'(hcu.interrupt_vector_address), 32'(e.vec));
                    chk("req_id", 32'(active_id), 32'(e.id));
                end
            end
            int_prev = hcu.interrupt;
        end
    end

    initial begin
        nreset            = 1'b0;
        irq_lines         = '0;
        global_ie         = 1'b0;
        mask_we           = 1'b0;
        mask_wdata        = '0;
        hcu.control_state = 3'h0;
        hcu.reti          = 1'b0;
        tick(3);

        // Reset values
        chk("rst_interrupt", 32'(hcu.interrupt), 32'd0);
        chk("rst_vector", 32'(hcu.interrupt_vector_address), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_mask", 32'(mask), 32'hff);
        chk("rst_in_service", 32'(in_service), 32'd0);
        chk("rst_active_id", 32'(active_id), 32'd0);
        nreset = 1'b1;
        tick(1);

        // Scenario 1: single source 3
        mask_we    = 1'b1;
        mask_wdata = 8'h00;
        global_ie  = 1'b1;
        tick(1);
        mask_we = 1'b0;
        chk("mask_loaded", 32'(mask), 32'h00);
        // reti in IDLE is ignored
        do_reti();
        push(4'd3, 14'h004C);
        irq_lines[3] = 1'b1;
        tick(1 + SYNC);
        chk("s1_pending", 32'(pending), 32'h08);
        chk("s1_no_req_yet", 32'(hcu.interrupt), 32'd0);
        irq_lines[3] = 1'b0;
        tick(1);
        chk("s1_latency", 32'(hcu.interrupt), 32'd1);
        ack_req(8'h00);
        do_reti();

        // Scenario 2: sources 5 and 1 together, 1 wins
        push(4'd1, 14'h0044);
        push(4'd5, 14'h0054);
        irq_lines = 8'h22;
        tick(1 + SYNC);
        chk("s2_pending", 32'(pending), 32'h22);
        irq_lines = 8'h00;
        tick(1);
        chk("s2_first_req", 32'(hcu.interrupt), 32'd1);
        ack_req(8'h20);
        do_reti();
        chk("s2_idle_after_reti", 32'(hcu.interrupt), 32'd0);
        tick(1);
        chk("s2_second_req", 32'(hcu.interrupt), 32'd1);
        ack_req(8'h00);
        do_reti();

        // Scenario 3: masked source 2, then unmask
        mask_we    = 1'b1;
        mask_wdata = 8'h04;
        tick(1);
        mask_we      = 1'b0;
        irq_lines[2] = 1'b1;
        tick(1 + SYNC);
        irq_lines[2] = 1'b0;
        chk("s3_masked_pending", 32'(pending), 32'h04);
        tick(2);
        chk("s3_masked_no_req", 32'(hcu.interrupt), 32'd0);
        push(4'd2, 14'h0048);
        mask_we    = 1'b1;
        mask_wdata = 8'h00;
        tick(1);
        mask_we = 1'b0;
        chk("s3_unmask_not_yet", 32'(hcu.interrupt), 32'd0);
        tick(1);
        chk("s3_unmask_req", 32'(hcu.interrupt), 32'd1);
        // reti, mask write and global_ie drop do not withdraw the request
        hcu.reti = 1'b1;
        tick(1);
        hcu.reti = 1'b0;
        chk("s3_reti_ignored", 32'(hcu.interrupt), 32'd1);
        mask_we    = 1'b1;
        mask_wdata = 8'hff;
        global_ie  = 1'b0;
        tick(1);
        mask_we = 1'b0;
        chk("s3_committed", 32'(hcu.interrupt), 32'd1);
        chk("s3_committed_vec", 32'(hcu.interrupt_vector_address), 32'h0048);
        ack_req(8'h00);
        do_reti();
        global_ie  = 1'b1;
        mask_we    = 1'b1;
        mask_wdata = 8'h00;
        tick(1);
        mask_we = 1'b0;

        // Scenario 4: new edge on source 0 in its acknowledge cycle
        push(4'd0, 14'h0040);
        push(4'd0, 14'h0040);
        irq_lines[0] = 1'b1;
        tick(1 + SYNC);
        irq_lines[0] = 1'b0;
        tick(1);
        chk("s4_req", 32'(hcu.interrupt), 32'd1);
        hcu.control_state = 3'h2;
        irq_lines[0]      = 1'b1;
        tick(1);
        hcu.control_state = 3'h0;
        irq_lines[0]      = 1'b0;
        tick(SYNC);
        chk("s4_set_wins", 32'(pending), 32'h01);
        chk("s4_in_service", 32'(in_service), 32'd1);
        do_reti();
        chk("s4_idle", 32'(hcu.interrupt), 32'd0);
        tick(1);
        chk("s4_rereq", 32'(hcu.interrupt), 32'd1);
        ack_req(8'h00);
        do_reti();

        // Scenario 5: reset during REQUEST
        push(4'd4, 14'h0050);
        irq_lines = 8'h50;
        tick(1 + SYNC);
        irq_lines = 8'h00;
        tick(1);
        chk("s5_req", 32'(hcu.interrupt), 32'd1);
        chk("s5_pending", 32'(pending), 32'h50);
        nreset = 1'b0;
        tick(1);
        chk("s5_rst_interrupt", 32'(hcu.interrupt), 32'd0);
        chk("s5_rst_pending", 32'(pending), 32'd0);
        chk("s5_rst_mask", 32'(mask), 32'hff);
        chk("s5_rst_in_service", 32'(in_service), 32'd0);
        chk("s5_rst_active_id", 32'(active_id), 32'd0);
        nreset = 1'b1;
        tick(4);
        chk("s5_stays_idle", 32'(hcu.interrupt), 32'd0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
